// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one GCD engine among NREQ requesters.
// Optional watchdog and timeout port: define GCD_TIMEOUT_EN.
module gcd_rr_scheduler #(
    parameter int N       = 8,
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] p_in,
    input  logic [NREQ*N-1:0] q_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [N-1:0]      r_out,
    output logic              busy,
    output logic [N-1:0]      eng_p,
    output logic [N-1:0]      eng_q,
    output logic              eng_start,
    input  logic [N-1:0]      eng_r,
    input  logic              eng_valid
`ifdef GCD_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] cand;
    logic          sel_found;
    logic [N-1:0]  sel_p;
    logic [N-1:0]  sel_q;
    logic          zero_q;
    logic          valid_q;
    logic          completion;

`ifdef GCD_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    // First requester above the last winner, wrapping, so the last winner ranks lowest.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    assign sel_p = p_in[int'(sel)*N +: N];
    assign sel_q = q_in[int'(sel)*N +: N];

    // valid_q keeps sampling through LAUNCH, so a valid still high from the last op is no edge.
    assign completion = eng_valid && !valid_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= PW'(NREQ - 1);
            gnt       <= '0;
            done      <= '0;
            r_out     <= '0;
            eng_p     <= '0;
            eng_q     <= '0;
            eng_start <= 1'b0;
            zero_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef GCD_TIMEOUT_EN
            timeout   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            valid_q   <= eng_valid;
            eng_start <= 1'b0;
            done      <= '0;
`ifdef GCD_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt       <= NREQ'(1) << sel;
                        eng_p     <= sel_p;
                        eng_q     <= sel_q;
                        ptr       <= sel;
                        zero_q    <= (sel_p == '0) || (sel_q == '0);
                        eng_start <= (sel_p != '0) && (sel_q != '0);
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // A zero operand never reaches the engine: gcd(x,0) = x, gcd(0,0) = 0.
                    if (zero_q) begin
                        r_out <= eng_p | eng_q;
                        done  <= gnt;
                        gnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
`ifdef GCD_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (completion) begin
                        r_out <= eng_r;
                        done  <= gnt;
                        gnt   <= '0;
                        state <= S_DONE;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                        r_out   <= '0;
                        done    <= gnt;
                        gnt     <= '0;
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
